sata_cmd_sequencer: RTL and testbench

Command sequencer for the SATA host controller's shadow-register port. Accepts one DMA read/write request (LBA, sector count, direction) from user logic and issues the task-file writes to the controller's host interface in order. Holds DMA request active while the transfer runs, waits for the interrupt-pending flag, then reads back the status register. Reports completion, device error or timeout. Sits between user/DMA logic and the controller's HOST_* / DMA_RQST / IPF pins, in the `clk` (CLK_OUT) domain.

---
 rtl/sata_cmd_sequencer_if.sv | 40 ++++
 rtl/sata_cmd_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sata_cmd_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sata_cmd_sequencer_if.sv
// Bundles the user request channel, the completion report and the controller
// shadow-register / DMA pins of sata_cmd_sequencer.
//   slave  : the sequencer (receives requests, drives HOST_* and DMA_RQST)
//   master : user logic plus the SATA controller (drives requests, LINKUP,
//            HOST_DATA_OUT, WRITE_HOLD_U, IPF)
interface sata_cmd_sequencer_if;
  logic        linkup;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [47:0] cmd_lba;
  logic [15:0] cmd_count;
  logic        busy;
  logic        done;
  logic [7:0]  done_status;
  logic        done_err;
  logic        done_timeout;
  logic        host_write_en;
  logic        host_read_en;
  logic [4:0]  host_addr_reg;
  logic [31:0] host_data_out;
  logic [31:0] host_data_in;
  logic        write_hold;
  logic        ipf;
  logic        dma_rqst;

  modport slave (
    input  linkup, cmd_valid, cmd_write, cmd_lba, cmd_count,
           host_data_in, write_hold, ipf,
    output cmd_ready, busy, done, done_status, done_err, done_timeout,
           host_write_en, host_read_en, host_addr_reg, host_data_out, dma_rqst
  );

  modport master (
    output linkup, cmd_valid, cmd_write, cmd_lba, cmd_count,
           host_data_in, write_hold, ipf,
    input  cmd_ready, busy, done, done_status, done_err, done_timeout,
           host_write_en, host_read_en, host_addr_reg, host_data_out, dma_rqst
  );
endinterface

// File: rtl/sata_cmd_sequencer.sv
// sata_cmd_sequencer: issues one READ/WRITE DMA command to the SATA host
// controller's shadow-register port.  Accepts a request, writes the task
// file, holds DMA_RQST while the transfer runs, waits for IPF, reads the
// status register and reports done / device error / timeout.
// Ports:
//   clk   : controller logic clock (CLK_OUT)
//   rst_n : synchronous active-low reset
//   bus   : sata_cmd_sequencer_if.slave (request, completion, HOST_*,
//           WRITE_HOLD_U, IPF, DMA_RQST, LINKUP)
// Optional feature macro: SATA_CMD_LBA48_EN (LBA48 exp writes + EXT opcodes).
// All outputs are registered.
module sata_cmd_sequencer #(
  parameter int unsigned ADDR_FEATURES  = 1,
  parameter int unsigned ADDR_SECCNT    = 2,
  parameter int unsigned ADDR_LBA_LO    = 3,
  parameter int unsigned ADDR_LBA_MID   = 4,
  parameter int unsigned ADDR_LBA_HI    = 5,
  parameter int unsigned ADDR_DEVICE    = 6,
  parameter int unsigned ADDR_CMD       = 7,
  parameter int unsigned EXP_OFFSET     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd150000000
) (
  input logic                  clk,
  input logic                  rst_n,
  sata_cmd_sequencer_if.slave  bus
);

`ifdef SATA_CMD_LBA48_EN
  localparam logic [3:0] LAST_STEP  = 4'd11;
  localparam logic [4:0] FIRST_ADDR = 5'(ADDR_FEATURES + EXP_OFFSET);
`else
  localparam logic [3:0] LAST_STEP  = 4'd6;
  localparam logic [4:0] FIRST_ADDR = 5'(ADDR_FEATURES);
`endif

  typedef enum logic [2:0] {
    IDLE, WR_REG, WAIT_IPF, RD_STAT, CAPTURE, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] timer_q, timer_d;
  logic [47:0] lba_q, lba_d;
  logic [15:0] count_q, count_d;
  logic        write_q, write_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  status_q, status_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        dma_q, dma_d;

  logic [3:0]  tbl_idx, base_idx;
  logic [4:0]  tbl_addr;
  logic [7:0]  tbl_data;
  logic        link_lost;

  // Task-file entry for the step after the one currently on the bus.
  // Step 0 (FEATURES = 0) is loaded directly at accept time.
  always_comb begin
    tbl_idx  = step_q + 4'd1;
    base_idx = tbl_idx;
    tbl_addr = '0;
    tbl_data = '0;
`ifdef SATA_CMD_LBA48_EN
    if (tbl_idx >= 4'd5) base_idx = tbl_idx - 4'd5;
`endif
    case (base_idx)
      4'd0: tbl_addr = 5'(ADDR_FEATURES);
      4'd1: begin tbl_addr = 5'(ADDR_SECCNT);  tbl_data = count_q[7:0];  end
      4'd2: begin tbl_addr = 5'(ADDR_LBA_LO);  tbl_data = lba_q[7:0];    end
      4'd3: begin tbl_addr = 5'(ADDR_LBA_MID); tbl_data = lba_q[15:8];   end
      4'd4: begin tbl_addr = 5'(ADDR_LBA_HI);  tbl_data = lba_q[23:16];  end
      4'd5: begin
        tbl_addr = 5'(ADDR_DEVICE);
`ifdef SATA_CMD_LBA48_EN
        tbl_data = 8'h40;
`else
        tbl_data = {4'h4, lba_q[27:24]};
`endif
      end
      4'd6: begin
        tbl_addr = 5'(ADDR_CMD);
`ifdef SATA_CMD_LBA48_EN
        tbl_data = write_q ? 8'h35 : 8'h25;
`else
        tbl_data = write_q ? 8'hCA : 8'hC8;
`endif
      end
      default: ;
    endcase
`ifdef SATA_CMD_LBA48_EN
    // Exp ("previous") registers share the base layout shifted by EXP_OFFSET.
    if (tbl_idx < 4'd5) begin
      tbl_addr = tbl_addr + 5'(EXP_OFFSET);
      case (tbl_idx)
        4'd1:    tbl_data = count_q[15:8];
        4'd2:    tbl_data = lba_q[31:24];
        4'd3:    tbl_data = lba_q[39:32];
        4'd4:    tbl_data = lba_q[47:40];
        default: tbl_data = '0;
      endcase
    end
`endif
  end

  assign link_lost = !bus.linkup &&
                     (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    timer_d     = timer_q;
    lba_d       = lba_q;
    count_d     = count_q;
    write_d     = write_q;
    cmd_ready_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    status_d    = status_q;
    err_d       = err_q;
    timeout_d   = timeout_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    dma_d       = dma_q;

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = bus.linkup;
        if (bus.cmd_valid && cmd_ready_q) begin
          lba_d       = bus.cmd_lba;
          count_d     = bus.cmd_count;
          write_d     = bus.cmd_write;
          busy_d      = 1'b1;
          dma_d       = 1'b1;
          status_d    = '0;
          err_d       = 1'b0;
          timeout_d   = 1'b0;
          step_d      = '0;
          wr_en_d     = 1'b1;
          addr_d      = FIRST_ADDR;
          data_d      = '0;
          cmd_ready_d = 1'b0;
          state_d     = WR_REG;
        end
      end
      WR_REG: begin
        // step_q is the write on the bus this cycle; a hold freezes it and
        // blanks the enable while address/data stay put.
        if (bus.write_hold) begin
          wr_en_d = 1'b0;
        end else if (step_q == LAST_STEP) begin
          wr_en_d = 1'b0;
          timer_d = '0;
          state_d = WAIT_IPF;
        end else begin
          step_d  = tbl_idx;
          wr_en_d = 1'b1;
          addr_d  = tbl_addr;
          data_d  = tbl_data;
        end
      end
      WAIT_IPF: begin
        if (bus.ipf) begin
          rd_en_d = 1'b1;
          addr_d  = 5'(ADDR_CMD);
          state_d = RD_STAT;
        end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
          done_d    = 1'b1;
          busy_d    = 1'b0;
          dma_d     = 1'b0;
          status_d  = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      RD_STAT: state_d = CAPTURE;
      CAPTURE: begin
        status_d = bus.host_data_in[7:0];
        err_d    = bus.host_data_in[0] | bus.host_data_in[5];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        dma_d    = 1'b0;
        state_d  = DONE;
      end
      DONE: begin
        cmd_ready_d = bus.linkup;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Link loss overrides whatever the state decided this cycle.
    if (link_lost) begin
      done_d    = 1'b1;
      busy_d    = 1'b0;
      dma_d     = 1'b0;
      status_d  = 8'hFF;
      err_d     = 1'b1;
      timeout_d = 1'b0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      state_d   = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      timer_q     <= '0;
      lba_q       <= '0;
      count_q     <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      dma_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      timer_q     <= timer_d;
      lba_q       <= lba_d;
      count_q     <= count_d;
      write_q     <= write_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_q    <= status_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      dma_q       <= dma_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.done_status   = status_q;
  assign bus.done_err      = err_q;
  assign bus.done_timeout  = timeout_q;
  assign bus.host_write_en = wr_en_q;
  assign bus.host_read_en  = rd_en_q;
  assign bus.host_addr_reg = addr_q;
  assign bus.host_data_out = {24'h000000, data_q};
  assign bus.dma_rqst      = dma_q;

  // Bits the task file never carries in this build.
  logic unused_bits;
`ifdef SATA_CMD_LBA48_EN
  assign unused_bits = ^bus.host_data_in[31:8];
`else
  assign unused_bits = ^{bus.host_data_in[31:8], lba_q[47:28], count_q[15:8]};
`endif

endmodule

// File: tb/tb_sata_cmd_sequencer.sv
module tb_sata_cmd_sequencer;
`ifdef SATA_CMD_LBA48_EN
  localparam int BASE = 5;
`else
  localparam int BASE = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_wr_cyc = 0;
  int   rd_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;

  logic [12:0] wq[$];   // {addr, data}
  logic [9:0]  dq[$];   // {status, err, timeout}

  sata_cmd_sequencer_if bus ();

  sata_cmd_sequencer #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic w, input logic [47:0] l, input logic [15:0] c);
`ifdef SATA_CMD_LBA48_EN
    wq.push_back({5'd9,  8'h00});
    wq.push_back({5'd10, c[15:8]});
    wq.push_back({5'd11, l[31:24]});
    wq.push_back({5'd12, l[39:32]});
    wq.push_back({5'd13, l[47:40]});
`endif
    wq.push_back({5'd1, 8'h00});
    wq.push_back({5'd2, c[7:0]});
    wq.push_back({5'd3, l[7:0]});
    wq.push_back({5'd4, l[15:8]});
    wq.push_back({5'd5, l[23:16]});
`ifdef SATA_CMD_LBA48_EN
    wq.push_back({5'd6, 8'h40});
    wq.push_back({5'd7, w ? 8'h35 : 8'h25});
`else
    wq.push_back({5'd6, {4'h4, l[27:24]}});
    wq.push_back({5'd7, w ? 8'hCA : 8'hC8});
`endif
  endtask

  // Scoreboard side: pops expected writes and completions as the DUT emits them.
  always @(negedge clk) begin
    logic [12:0] w;
    logic [9:0]  d;
    if (bus.host_write_en) begin
      checks++;
      assert (wq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0d data=0x%0h expected none",
               bus.host_addr_reg, bus.host_data_out);
      end
      if (wq.size() != 0) begin
        w = wq.pop_front();
        check("wr_addr", 64'(bus.host_addr_reg), 64'(w[12:8]));
        check("wr_data", 64'(bus.host_data_out), 64'({24'h0, w[7:0]}));
      end
      last_wr_cyc = cyc;
    end
    if (bus.host_read_en) begin
      check("rd_addr", 64'(bus.host_addr_reg), 64'd7);
      rd_cyc = cyc;
    end
    if (bus.done) begin
      checks++;
      assert (dq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done observed status=0x%0h expected none", bus.done_status);
      end
      if (dq.size() != 0) begin
        d = dq.pop_front();
        check("done_status",  64'(bus.done_status),  64'(d[9:2]));
        check("done_err",     64'(bus.done_err),     64'(d[1]));
        check("done_timeout", 64'(bus.done_timeout), 64'(d[0]));
      end
      check("busy_at_done", 64'(bus.busy), 64'd0);
      check("dma_at_done",  64'(bus.dma_rqst), 64'd0);
      done_cyc = cyc;
      done_cnt++;
    end
  end

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cmd_ready"},  64'(bus.cmd_ready), 64'd0);
    check({pfx, "_busy"},       64'(bus.busy), 64'd0);
    check({pfx, "_done"},       64'(bus.done), 64'd0);
    check({pfx, "_status"},     64'(bus.done_status), 64'd0);
    check({pfx, "_err"},        64'(bus.done_err), 64'd0);
    check({pfx, "_timeout"},    64'(bus.done_timeout), 64'd0);
    check({pfx, "_wr_en"},      64'(bus.host_write_en), 64'd0);
    check({pfx, "_rd_en"},      64'(bus.host_read_en), 64'd0);
    check({pfx, "_addr"},       64'(bus.host_addr_reg), 64'd0);
    check({pfx, "_data"},       64'(bus.host_data_out), 64'd0);
    check({pfx, "_dma"},        64'(bus.dma_rqst), 64'd0);
  endtask

  task automatic issue(input logic w, input logic [47:0] l, input logic [15:0] c, output int acc);
    push_cmd(w, l, c);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_lba   = l;
    bus.cmd_count = c;
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) tick();
    check("cmd_ready_before_accept", 64'(bus.cmd_ready), 64'd1);
    acc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    check("busy_after_accept",  64'(bus.busy), 64'd1);
    check("dma_after_accept",   64'(bus.dma_rqst), 64'd1);
    check("first_write_n_plus1", 64'(bus.host_write_en), 64'd1);
  endtask

  task automatic wait_writes();
    for (int i = 0; i < 80 && wq.size() != 0; i++) tick();
    check("writes_drained", 64'(wq.size()), 64'd0);
  endtask

  task automatic wait_done(input int start, input int limit);
    for (int i = 0; i < limit && done_cnt == start; i++) tick();
    check("done_seen", 64'(done_cnt), 64'(start + 1));
  endtask

  task automatic pulse_ipf(input logic [7:0] status, output int c);
    bus.ipf          = 1'b1;
    bus.host_data_in = {24'hABCDEF, status};
    c = cyc;
    tick();
    bus.ipf = 1'b0;
  endtask

  initial begin
    int n, c, dc;
    rst_n            = 1'b0;
    bus.linkup       = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_write    = 1'b0;
    bus.cmd_lba      = '0;
    bus.cmd_count    = '0;
    bus.host_data_in = '0;
    bus.write_hold   = 1'b0;
    bus.ipf          = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // 28-bit read, no hold, status 0x50
    issue(1'b0, 48'h000000123456, 16'd8, n);
    wait_writes();
    check("t1_cmd_cycle", 64'(last_wr_cyc), 64'(n + 7 + BASE));
    dq.push_back({8'h50, 1'b0, 1'b0});
    repeat (20) tick();
    dc = done_cnt;
    pulse_ipf(8'h50, c);
    wait_done(dc, 10);
    check("t1_rd_cycle",   64'(rd_cyc),   64'(c + 1));
    check("t1_done_cycle", 64'(done_cyc), 64'(c + 3));
    tick();
    check("t1_ready_after_done", 64'(bus.cmd_ready), 64'd1);

    // Write with write_hold during the LBA_MID step, count 0, status 0x51
    issue(1'b1, 48'h0000000ABCDEF, 16'h0000, n);
    repeat (3 + BASE) tick();
    bus.write_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_wr_en", 64'(bus.host_write_en), 64'd0);
      check("hold_addr",  64'(bus.host_addr_reg), 64'd4);
      check("hold_data",  64'(bus.host_data_out), 64'h0000_00CD);
    end
    bus.write_hold = 1'b0;
    wait_writes();
    check("t2_cmd_cycle", 64'(last_wr_cyc), 64'(n + 10 + BASE));
    dq.push_back({8'h51, 1'b1, 1'b0});
    repeat (3) tick();
    dc = done_cnt;
    pulse_ipf(8'h51, c);
    wait_done(dc, 10);

    // Device fault (DF bit only)
    issue(1'b0, 48'h000000FEDCBA, 16'h00FF, n);
    wait_writes();
    dq.push_back({8'h70, 1'b1, 1'b0});
    tick();
    dc = done_cnt;
    pulse_ipf(8'h70, c);
    wait_done(dc, 10);

    // Timeout: no ipf
    dc = done_cnt;
    issue(1'b1, 48'h000001020304, 16'd1, n);
    dq.push_back({8'h00, 1'b1, 1'b1});
    wait_done(dc, 200);
    check("timeout_cycle", 64'(done_cyc), 64'(n + 8 + BASE + 100));

    // Link loss during WAIT_IPF, coinciding with ipf
    issue(1'b0, 48'h000000111111, 16'd4, n);
    wait_writes();
    dq.push_back({8'hFF, 1'b1, 1'b0});
    repeat (5) tick();
    dc = done_cnt;
    bus.linkup       = 1'b0;
    bus.ipf          = 1'b1;
    bus.host_data_in = 32'h0000_0050;
    c = cyc;
    tick();
    bus.ipf = 1'b0;
    wait_done(dc, 10);
    check("linkloss_done_cycle", 64'(done_cyc), 64'(c + 1));
    repeat (2) tick();
    check("ready_without_link", 64'(bus.cmd_ready), 64'd0);
    bus.linkup = 1'b1;
    tick();

    // Reset in the middle of WR_REG
    dc = done_cnt;
    issue(1'b1, 48'h000000222222, 16'd2, n);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check_reset_vals("midreset");
    wq.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("midreset_no_done", 64'(done_cnt), 64'(dc));
    check("midreset_ready",   64'(bus.cmd_ready), 64'd1);

    // Wide LBA / count vector
    issue(1'b0, 48'hA1B2C3D4E5F6, 16'h0102, n);
    wait_writes();
    check("wide_cmd_cycle", 64'(last_wr_cyc), 64'(n + 7 + BASE));
    dq.push_back({8'h40, 1'b0, 1'b0});
    tick();
    dc = done_cnt;
    pulse_ipf(8'h40, c);
    wait_done(dc, 10);
    repeat (2) tick();
    check("queues_empty", 64'(dq.size() + wq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
